// File: rtl/dose_seq_pkg.sv
// Shared state encoding, pump/valve phase decode and default counter width.
// S_FLUSH exists only when REAGENT_DOSE_FLUSH_EN is defined.
package dose_seq_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DOSE2  = 3'd1,
        S_DOSE3  = 3'd2,
        S_DOSE1  = 3'd3,
        S_SETTLE = 3'd4,
`ifdef REAGENT_DOSE_FLUSH_EN
        S_FLUSH  = 3'd5,
`endif
        S_DONE   = 3'd6
    } state_t;

    // Pump enables for a phase, ordered {pump1, pump2, pump3}.
    function automatic logic [2:0] pump_mask(input state_t s);
        case (s)
            S_DOSE1: pump_mask = 3'b100;
            S_DOSE2: pump_mask = 3'b010;
            S_DOSE3: pump_mask = 3'b001;
`ifdef REAGENT_DOSE_FLUSH_EN
            S_FLUSH: pump_mask = 3'b111;
`endif
            default: pump_mask = 3'b000;
        endcase
    endfunction

    function automatic logic valve_open(input state_t s);
        case (s)
            S_SETTLE: valve_open = 1'b1;
`ifdef REAGENT_DOSE_FLUSH_EN
            S_FLUSH:  valve_open = 1'b1;
`endif
            default:  valve_open = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dose_timer.sv
// Loadable down-counter shared by every dosing phase; expire marks the last
// cycle of a phase and the count parks at zero instead of wrapping.
module dose_timer
    import dose_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count register: load on phase entry, otherwise decrement down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == ONE);

endmodule

// File: rtl/reagent_dose_seq.sv
// Three-inlet reagent dosing sequencer: soln2, soln3, soln1, settle, optional
// flush (REAGENT_DOSE_FLUSH_EN), done. All outputs are registered.
module reagent_dose_seq
    import dose_seq_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int FLUSH_LEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dose1_len,
    input  logic [CNT_W-1:0] dose2_len,
    input  logic [CNT_W-1:0] dose3_len,
    input  logic [CNT_W-1:0] settle_len,
    output logic             pump1_en,
    output logic             pump2_en,
    output logic             pump3_en,
    output logic             valve_out_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_LEN);
`ifdef REAGENT_DOSE_FLUSH_EN
    localparam state_t AFTER_SETTLE = S_FLUSH;
`else
    localparam state_t AFTER_SETTLE = S_DONE;
`endif

    state_t           state_r, next_s;
    state_t           from_idle_s, after_dose2_s, after_dose3_s, after_dose1_s;
    logic [CNT_W-1:0] len1_r, len2_r, len3_r, lens_r;
    logic [CNT_W-1:0] l1_s, l2_s, l3_s, ls_s, load_val_s;
    logic             armed_r, idle_s, accept_s, abort_s, load_s, expire_s;

    assign idle_s   = (state_r == S_IDLE);
    assign accept_s = idle_s && start && armed_r;
    assign abort_s  = abort && !idle_s;

    // In IDLE the live inputs decide the first phase; afterwards the latched copies rule.
    assign l1_s = idle_s ? dose1_len  : len1_r;
    assign l2_s = idle_s ? dose2_len  : len2_r;
    assign l3_s = idle_s ? dose3_len  : len3_r;
    assign ls_s = idle_s ? settle_len : lens_r;

    // Next-state and timer load: zero-length phases are skipped without a gap cycle.
    always_comb begin
        after_dose1_s = (ls_s != '0) ? S_SETTLE : AFTER_SETTLE;
        after_dose3_s = (l1_s != '0) ? S_DOSE1  : after_dose1_s;
        after_dose2_s = (l3_s != '0) ? S_DOSE3  : after_dose3_s;
        from_idle_s   = (l2_s != '0) ? S_DOSE2  : after_dose2_s;
        next_s        = state_r;
        if (abort_s) begin
            next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:   next_s = accept_s ? from_idle_s   : S_IDLE;
                S_DOSE2:  next_s = expire_s ? after_dose2_s : S_DOSE2;
                S_DOSE3:  next_s = expire_s ? after_dose3_s : S_DOSE3;
                S_DOSE1:  next_s = expire_s ? after_dose1_s : S_DOSE1;
                S_SETTLE: next_s = expire_s ? AFTER_SETTLE  : S_SETTLE;
`ifdef REAGENT_DOSE_FLUSH_EN
                S_FLUSH:  next_s = expire_s ? S_DONE        : S_FLUSH;
`endif
                S_DONE:   next_s = S_IDLE;
                default:  next_s = S_IDLE;
            endcase
        end
        load_s = (next_s != state_r);
        case (next_s)
            S_DOSE2:  load_val_s = l2_s;
            S_DOSE3:  load_val_s = l3_s;
            S_DOSE1:  load_val_s = l1_s;
            S_SETTLE: load_val_s = ls_s;
            S_IDLE:   load_val_s = '0;
            S_DONE:   load_val_s = '0;
            default:  load_val_s = FLUSH_CNT;
        endcase
    end

    dose_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .expire   (expire_s)
    );

    // State register; armed_r blocks a start on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= next_s;
            armed_r <= 1'b1;
        end
    end

    // Run lengths captured once, on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len1_r <= '0;
            len2_r <= '0;
            len3_r <= '0;
            lens_r <= '0;
        end else if (accept_s) begin
            len1_r <= dose1_len;
            len2_r <= dose2_len;
            len3_r <= dose3_len;
            lens_r <= settle_len;
        end else begin
            len1_r <= len1_r;
            len2_r <= len2_r;
            len3_r <= len3_r;
            lens_r <= lens_r;
        end
    end

    // Outputs decoded from the next state so they change together with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {pump1_en, pump2_en, pump3_en} <= 3'b000;
            valve_out_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            {pump1_en, pump2_en, pump3_en} <= pump_mask(next_s);
            valve_out_en <= valve_open(next_s);
            busy         <= (next_s != S_IDLE);
            done         <= (next_s == S_DONE);
            err          <= abort_s;
        end
    end

endmodule

// File: tb/tb_reagent_dose_seq.sv
// Scoreboard bench for reagent_dose_seq: stimulus pushes expected run profiles,
// a negedge monitor accumulates pump/valve activity and checks on done/err.
module tb_reagent_dose_seq;

    localparam int CW      = 4;
    localparam int FLUSH_P = 4;
`ifdef REAGENT_DOSE_FLUSH_EN
    localparam int FL = FLUSH_P;
`else
    localparam int FL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] d1, d2, d3, st;
    logic          pump1_en, pump2_en, pump3_en, valve_out_en, busy, done, err;

    reagent_dose_seq #(.CNT_W(CW), .FLUSH_LEN(FLUSH_P)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dose1_len    (d1),
        .dose2_len    (d2),
        .dose3_len    (d3),
        .settle_len   (st),
        .pump1_en     (pump1_en),
        .pump2_en     (pump2_en),
        .pump3_en     (pump3_en),
        .valve_out_en (valve_out_en),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        bit is_err;
        int ev_off;
        int c2, c3, c1, cv, cf;
        int o2, o3, o1, ov, of;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   a2, a3, a1, av, af, f2, f3, f1, fv, ff, bad;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Offsets count from 1 = the cycle after the accepting edge t.
    function automatic exp_t model(input int t, input int l2, input int l3,
                                   input int l1, input int ls);
        exp_t e;
        int   off;
        e = '{default: 0};
        e.t = t;
        off = 1;
        if (l2 > 0) e.o2 = off;
        e.c2 = l2; off += l2;
        if (l3 > 0) e.o3 = off;
        e.c3 = l3; off += l3;
        if (l1 > 0) e.o1 = off;
        e.c1 = l1; off += l1;
        if (ls > 0) e.ov = off;
        e.cv = ls; off += ls;
        if (FL > 0) e.of = off;
        e.cf = FL; off += FL;
        e.ev_off = off;
        return e;
    endfunction

    function automatic int rel(input int first, input int t);
        return (first == 0) ? 0 : first - t + 1;
    endfunction

    task automatic clr();
        a2 = 0; a3 = 0; a1 = 0; av = 0; af = 0;
        f2 = 0; f3 = 0; f1 = 0; fv = 0; ff = 0; bad = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: classify every cycle, compare a full run profile on done/err.
    initial begin
        logic [2:0] p;
        exp_t       e;
        clr();
        forever begin
            @(negedge clk);
            if (rst) begin
                clr();
            end else begin
                p = {pump1_en, pump2_en, pump3_en};
                if (p == 3'b111 && valve_out_en) begin af++; if (ff == 0) ff = cyc; end
                else if (p == 3'b010 && !valve_out_en) begin a2++; if (f2 == 0) f2 = cyc; end
                else if (p == 3'b001 && !valve_out_en) begin a3++; if (f3 == 0) f3 = cyc; end
                else if (p == 3'b100 && !valve_out_en) begin a1++; if (f1 == 0) f1 = cyc; end
                else if (p == 3'b000 && valve_out_en) begin av++; if (fv == 0) fv = cyc; end
                else if (p != 3'b000) bad++;
                if (done || err) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_event", int'({done, err}), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("event_is_err", int'(err), int'(e.is_err));
                        chk("event_is_done", int'(done), int'(!e.is_err));
                        chk("event_offset", cyc - e.t + 1, e.ev_off);
                        chk("busy_at_event", int'(busy), int'(!e.is_err));
                        chk("pump2_cycles", a2, e.c2);
                        chk("pump3_cycles", a3, e.c3);
                        chk("pump1_cycles", a1, e.c1);
                        chk("settle_cycles", av, e.cv);
                        chk("flush_cycles", af, e.cf);
                        chk("pump2_first", rel(f2, e.t), e.o2);
                        chk("pump3_first", rel(f3, e.t), e.o3);
                        chk("pump1_first", rel(f1, e.t), e.o1);
                        chk("settle_first", rel(fv, e.t), e.ov);
                        chk("flush_first", rel(ff, e.t), e.of);
                        chk("pump_exclusive", bad, 0);
                        clr();
                    end
                end
            end
        end
    end

    task automatic run(input int l2, input int l3, input int l1, input int ls);
        exp_t e;
        d2 = CW'(l2); d3 = CW'(l3); d1 = CW'(l1); st = CW'(ls);
        start = 1'b1;
        e = model(cyc + 1, l2, l3, l1, ls);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        d1 = 4'd9; d2 = 4'd9; d3 = 4'd9; st = 4'd9;
        repeat (e.ev_off + 2) @(negedge clk);
    endtask

    initial begin
        exp_t e1, e2;
        int   t;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; st = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({pump1_en, pump2_en, pump3_en, valve_out_en, busy, done, err}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(3, 4, 5, 2);
        run(2, 0, 2, 0);
        run(0, 0, 0, 0);
        run(15, 0, 0, 0);
        run(1, 1, 1, 1);

        // Abort two cycles into the pump3 phase of a 3/4/5/2 run.
        d2 = 4'd3; d3 = 4'd4; d1 = 4'd5; st = 4'd2;
        start = 1'b1;
        e1 = '{default: 0};
        e1.t = cyc + 1; e1.is_err = 1'b1; e1.ev_off = 6;
        e1.c2 = 3; e1.o2 = 1; e1.c3 = 2; e1.o3 = 4;
        sb.push_back(e1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", int'(busy), 0);

        // Start held high, lengths changed mid-run: exactly one rerun after DONE.
        d2 = 4'd1; d3 = 4'd2; d1 = 4'd1; st = 4'd1;
        start = 1'b1;
        t  = cyc + 1;
        e1 = model(t, 1, 2, 1, 1);
        e2 = model(t + e1.ev_off + 1, 2, 1, 1, 0);
        sb.push_back(e1);
        sb.push_back(e2);
        @(negedge clk);
        d2 = 4'd2; d3 = 4'd1; d1 = 4'd1; st = 4'd0;
        repeat (e2.t - cyc) @(negedge clk);
        start = 1'b0;
        repeat (e2.ev_off + 2) @(negedge clk);

        // Reset in the middle of DOSE1.
        d2 = 4'd1; d3 = 4'd1; d1 = 4'd4; st = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pump1_before_rst", int'(pump1_en), 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", int'({pump1_en, pump2_en, pump3_en, valve_out_en, busy, done, err}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("no_start_after_rst", int'(busy), 0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_after_rst", int'(busy), 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reagent_dose_seq.md
REAGENT_DOSE_SEQ -- requirements
Module: reagent_dose_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of every dose, settle and flush counter.
REQ-002 SHALL have parameter FLUSH_LEN, default 64: flush duration in cycles; legal range 1..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1: request one dosing run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1: terminate the run in progress.
REQ-007 SHALL have ports dose1_len, dose2_len, dose3_len  input  CNT_W: pump-on cycles for inlets soln1, soln2, soln3.
REQ-008 SHALL have port settle_len  input  CNT_W: cycles with all pumps off and the outlet valve open.
REQ-009 SHALL have ports pump1_en, pump2_en, pump3_en  output  1: drive the soln1, soln2, soln3 inlet pumps.
REQ-010 SHALL have port valve_out_en  output  1: open the chip outlet valve ("out").
REQ-011 SHALL have ports busy, done, err  output  1: run active; one-cycle completion pulse; one-cycle abort pulse.

Function
REQ-012 SHALL implement FSM states IDLE, DOSE2, DOSE3, DOSE1, SETTLE, FLUSH, DONE; DOSE2 and DOSE3 come first because soln2 and soln3 pass through long serpentine delay chains before they merge with soln1.
REQ-013 SHALL latch all four length inputs on the cycle start is accepted; later input changes SHALL NOT affect the run.
REQ-014 SHALL accept start in IDLE at edge t and assert pump2_en from cycle t+1 for exactly dose2_len cycles, then pump3_en for dose3_len cycles, then pump1_en for dose1_len cycles.
REQ-015 SHALL skip any phase whose latched length is 0 with no idle cycle; if all lengths are 0, the next phase starts at t+1.
REQ-016 SHALL hold all pumps off during SETTLE for settle_len cycles with valve_out_en=1; settle_len=0 skips SETTLE.
REQ-017 SHALL, in FLUSH, assert all three pumps and valve_out_en for FLUSH_LEN cycles.
REQ-018 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-019 SHALL keep pumps mutually exclusive outside FLUSH: at most one pump*_en high.
REQ-020 SHALL ignore start while busy, with no queueing.
REQ-021 SHALL, on abort in any non-IDLE state, deassert all pumps and valve_out_en on the next cycle, pulse err once, skip done and go to IDLE.
REQ-022 SHALL give abort priority over a simultaneous phase completion or DONE; abort in IDLE SHALL have no effect.
REQ-023 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-024 SHALL use down-counters that never wrap; a length of 2^CNT_W-1 SHALL give exactly that many cycles.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, all counters 0, and all outputs 0, asynchronously.
REQ-026 SHALL, on reset during a run, drop all pumps immediately and SHALL NOT pulse done or err.
REQ-027 SHALL NOT accept a start that is high on the first edge after rst is released.

Configuration
REQ-028 SHALL use macro REAGENT_DOSE_FLUSH_EN: when defined, SETTLE goes to FLUSH, then to DONE.
REQ-029 SHALL, without REAGENT_DOSE_FLUSH_EN, go from SETTLE to DONE, omit the FLUSH state, ignore FLUSH_LEN and never assert more than one pump.

Structure
REQ-030 SHALL take the state enum, phase encoding and default CNT_W from shared package dose_seq_pkg.
REQ-031 SHALL reuse one sub-module, dose_timer (load value, decrement, expire flag), for every phase.

Verification
REQ-032 SHALL cover: lengths 3/4/5, settle 2, flush off -> pump2 high 3 cycles from t+1, pump3 4, pump1 5, valve 2, done at t+15.
REQ-033 SHALL cover: dose3_len=0, others 2, settle 0 -> pump2 2 cycles, then pump1 directly, done at t+5.
REQ-034 SHALL cover: abort during pump3 phase -> next cycle all pumps 0, err 1 cycle, busy 0, no done.
REQ-035 SHALL cover: FLUSH_EN defined, FLUSH_LEN=4, lengths 1/1/1, settle 1 -> all pumps high 4 cycles after settle, done at t+9.
REQ-036 SHALL cover: start held high throughout, plus length inputs changed mid-run -> one run with the latched lengths, next run starts only after DONE.
REQ-037 SHALL cover: rst asserted mid-DOSE1 -> outputs 0 asynchronously, IDLE after release, no done or err.
